// File: rtl/fpdiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fpdiv_pkg
//  Description : Shared types and constants for the fp32 divider scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package fpdiv_pkg;

   localparam int FP32_W              = 32;
   localparam int DIV_LATENCY_DEFAULT = 12;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/fpdiv_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : fpdiv_scheduler_if
//  Description : Request, response and divider-side signals of the shared
//                fp32 divider scheduler. slave = scheduler, master = issue
//                logic / divider wrapper.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fpdiv_scheduler_if #(
   parameter int NREQ = 4
);
   localparam int IDW = $clog2(NREQ);

   logic [NREQ-1:0]                      req_valid;
   logic [NREQ-1:0]                      req_ready;
   logic [NREQ*fpdiv_pkg::FP32_W-1:0]    req_dividend;
   logic [NREQ*fpdiv_pkg::FP32_W-1:0]    req_divisor;
   logic [NREQ-1:0]                      req_rm;
   logic                                 resp_valid;
   logic                                 resp_ready;
   logic [IDW-1:0]                       resp_id;
   logic [fpdiv_pkg::FP32_W-1:0]         resp_quotient;
   logic                                 busy;
   logic                                 div_start;
   logic [fpdiv_pkg::FP32_W-1:0]         div_dividend;
   logic [fpdiv_pkg::FP32_W-1:0]         div_divisor;
   logic                                 div_rm;
   logic [fpdiv_pkg::FP32_W-1:0]         div_quotient;

   modport slave (
      input  req_valid, req_dividend, req_divisor, req_rm, resp_ready, div_quotient,
      output req_ready, resp_valid, resp_id, resp_quotient, busy,
             div_start, div_dividend, div_divisor, div_rm
   );

   modport master (
      output req_valid, req_dividend, req_divisor, req_rm, resp_ready, div_quotient,
      input  req_ready, resp_valid, resp_id, resp_quotient, busy,
             div_start, div_dividend, div_divisor, div_rm
   );

endinterface
`default_nettype wire

// File: rtl/fpdiv_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Grants the first set
//                request searching upward from ptr, wrapping modulo N.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   input  logic                 en,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] grant_id
);
   localparam int IDW = $clog2(N);

   logic w_found;
   int   w_idx;

   // Rotating priority search; at most one grant bit is ever set.
   always_comb begin
      grant    = '0;
      grant_id = '0;
      w_found  = 1'b0;
      w_idx    = 0;
      for (int k = 0; k < N; k++) begin
         w_idx = (int'(ptr) + k) % N;
         if (en && !w_found && req[w_idx]) begin
            w_found        = 1'b1;
            grant[w_idx]   = 1'b1;
            grant_id       = IDW'(w_idx);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/fpdiv_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : fpdiv_scheduler
//  Description : Shares one multi-cycle, non-pipelined fp32 divider between
//                NREQ requesters. Round-robin grant, operand latching, fixed
//                latency wait, and a valid/ready tagged response.
//  Revision    : 1.0 - initial release
// ============================================================================
module fpdiv_scheduler
   import fpdiv_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int LATENCY = DIV_LATENCY_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   fpdiv_scheduler_if.slave bus
);
   localparam int IDW = $clog2(NREQ);
   localparam int CW  = $clog2(LATENCY);

   localparam logic [CW-1:0]  c_count_init = CW'(LATENCY - 1);
   localparam logic [IDW-1:0] c_last_id    = IDW'(NREQ - 1);

   sched_state_t          r_state;
   sched_state_t          w_state_next;
   logic [CW-1:0]         r_count;
   logic [IDW-1:0]        r_rr_ptr;
   logic [IDW-1:0]        r_id;
   logic [FP32_W-1:0]     r_dividend;
   logic [FP32_W-1:0]     r_divisor;
   logic                  r_rm;
   logic                  r_resp_valid;
   logic [FP32_W-1:0]     r_resp_quotient;

   logic                  w_arb_en;
   logic [NREQ-1:0]       w_grant;
   logic [IDW-1:0]        w_grant_id;
   logic                  w_accept;

   rr_arbiter #(.N(NREQ)) u_arb (
      .req      (bus.req_valid),
      .ptr      (r_rr_ptr),
      .en       (w_arb_en),
      .grant    (w_grant),
      .grant_id (w_grant_id)
   );

   // The arbiter only grants in IDLE, so any grant bit is an accept.
   assign w_accept = |w_grant;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_next;
   end

   // Next-state logic: IDLE -> RUN on accept, RUN -> DONE at count 0,
   // DONE -> IDLE on response handshake.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_accept)                          w_state_next = RUN;
         RUN:     if (r_count == '0)                     w_state_next = DONE;
         DONE:    if (r_resp_valid && bus.resp_ready)    w_state_next = IDLE;
         default:                                        w_state_next = IDLE;
      endcase
   end

   // Control outputs decoded from the current state.
   always_comb begin
      w_arb_en      = (r_state == IDLE);
      bus.req_ready = w_grant;
      bus.busy      = (r_state != IDLE);
      bus.div_start = (r_state == RUN) && (r_count == c_count_init);
   end

   // Operand latch, latency counter, round-robin pointer and response capture.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count         <= '0;
         r_rr_ptr        <= '0;
         r_id            <= '0;
         r_dividend      <= '0;
         r_divisor       <= '0;
         r_rm            <= 1'b0;
         r_resp_valid    <= 1'b0;
         r_resp_quotient <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_id       <= w_grant_id;
                  r_dividend <= bus.req_dividend[w_grant_id*FP32_W +: FP32_W];
                  r_divisor  <= bus.req_divisor[w_grant_id*FP32_W +: FP32_W];
                  r_rm       <= bus.req_rm[w_grant_id];
                  r_count    <= c_count_init;
                  r_rr_ptr   <= (w_grant_id == c_last_id) ? '0 : w_grant_id + 1'b1;
               end
            end
            RUN: begin
               if (r_count == '0) begin
                  r_resp_quotient <= bus.div_quotient;
                  r_resp_valid    <= 1'b1;
               end else begin
                  r_count <= r_count - 1'b1;
               end
            end
            DONE: begin
               if (r_resp_valid && bus.resp_ready) r_resp_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.div_dividend  = r_dividend;
   assign bus.div_divisor   = r_divisor;
   assign bus.div_rm        = r_rm;
   assign bus.resp_valid    = r_resp_valid;
   assign bus.resp_id       = r_id;
   assign bus.resp_quotient = r_resp_quotient;

endmodule
`default_nettype wire
